demux1_4_slot: RTL and testbench

//  Registered 1:4 demultiplexer. It is the receive-side counterpart of mux4_1.
//  A single W-bit input stream with a valid/ready handshake is steered by s into one of four

---
 rtl/demux1_4_slot_pkg.sv | 7 +
 rtl/demux1_4_slot_slot.sv | 38 +++
 rtl/demux1_4_slot.sv | 56 +++++
 tb/tb_demux1_4_slot.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux1_4_slot_pkg.sv
// Lane count and select encoding shared by the 1:4 demux and the mux4_1 benches.
package mux_pkg;
  localparam int N_LANE = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {L1, L2, L3, L4} lane_e;
endpackage

// File: rtl/demux1_4_slot_slot.sv
// One output lane: a one-entry data slot with valid flag and a saturating delivered-word counter.
module demux_slot #(
  parameter int W    = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fill,
  input  logic [W-1:0]    d,
  input  logic            take,
  output logic [W-1:0]    q,
  output logic            valid,
  output logic [CNTW-1:0] cnt
);

  logic hs;
  assign hs = valid & take;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      // A refill in the handshake cycle keeps the slot full with the new word.
      if (fill) begin
        q     <= d;
        valid <= 1'b1;
      end else if (hs) begin
        valid <= 1'b0;
      end
      if (hs && (cnt != {CNTW{1'b1}})) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/demux1_4_slot.sv
// Registered 1:4 demultiplexer: steers a valid/ready input stream into four one-entry lanes.
module demux1_4_slot
  import mux_pkg::*;
#(
  parameter int W    = 4,
  parameter int CNTW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           i,
  input  logic [SEL_W-1:0]       s,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic [W-1:0]           o1,
  output logic [W-1:0]           o2,
  output logic [W-1:0]           o3,
  output logic [W-1:0]           o4,
  output logic [N_LANE-1:0]      o_valid,
  input  logic [N_LANE-1:0]      o_ready,
  output logic [N_LANE*CNTW-1:0] cnt
);

  lane_e             sel;
  logic              acc;
  logic [N_LANE-1:0] fill;
  logic [W-1:0]      lane_q [N_LANE];

  assign sel     = lane_e'(s);
  // Only the selected lane can stall the source.
  assign i_ready = ~rst & (~o_valid[sel] | o_ready[sel]);
  assign acc     = i_valid & i_ready;

  always_comb begin
    fill      = '0;
    fill[sel] = acc;
  end

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    demux_slot #(.W(W), .CNTW(CNTW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .fill  (fill[k]),
      .d     (i),
      .take  (o_ready[k]),
      .q     (lane_q[k]),
      .valid (o_valid[k]),
      .cnt   (cnt[k*CNTW +: CNTW])
    );
  end

  assign o1 = lane_q[0];
  assign o2 = lane_q[1];
  assign o3 = lane_q[2];
  assign o4 = lane_q[3];

endmodule

// File: tb/tb_demux1_4_slot.sv
// Scoreboard bench for demux1_4_slot: per-lane expected-word queues, counters and handshake model.
module tb_demux1_4_slot;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i;
  logic [1:0] s;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] o1, o2, o3, o4;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [31:0] cnt;

  logic [3:0] i2;
  logic [1:0] s2;
  logic       v2;
  logic       rdy2;
  logic [3:0] p1, p2, p3, p4;
  logic [3:0] pv;
  logic [3:0] r2;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  demux1_4_slot #(.W(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .i(i), .s(s), .i_valid(i_valid), .i_ready(i_ready),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o_valid(o_valid), .o_ready(o_ready), .cnt(cnt)
  );

  demux1_4_slot #(.W(4), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .i(i2), .s(s2), .i_valid(v2), .i_ready(rdy2),
    .o1(p1), .o2(p2), .o3(p3), .o4(p4), .o_valid(pv), .o_ready(r2), .cnt(cnt2)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q [4][$];
  logic [3:0] mlast [4];
  logic [7:0] mcnt  [4];
  int         n_acc;
  logic       last_acc;
  logic [3:0] lane_o [4];

  assign lane_o[0] = o1;
  assign lane_o[1] = o2;
  assign lane_o[2] = o3;
  assign lane_o[3] = o4;

  // Inputs are set just after a posedge; outputs are checked at negedge, model advances at posedge.
  task automatic tick();
    logic       exp_rdy;
    logic       acc;
    logic [3:0] exp_o;
    @(negedge clk);
    exp_rdy = !rst && ((exp_q[s].size() == 0) || o_ready[s]);
    checks++;
    if (i_ready !== exp_rdy) begin
      failures++;
      $display("FAIL i_ready got %b exp %b at %0t", i_ready, exp_rdy, $time);
    end
    for (int k = 0; k < 4; k++) begin
      exp_o = (exp_q[k].size() != 0) ? exp_q[k][0] : mlast[k];
      checks++;
      if (o_valid[k] !== (exp_q[k].size() != 0)) begin
        failures++;
        $display("FAIL o_valid lane%0d got %b exp %b at %0t", k, o_valid[k], exp_q[k].size() != 0, $time);
      end
      checks++;
      if (lane_o[k] !== exp_o) begin
        failures++;
        $display("FAIL data lane%0d got %h exp %h at %0t", k, lane_o[k], exp_o, $time);
      end
    end
    acc = i_valid && exp_rdy;
    last_acc = acc;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        mlast[k] = 4'h0;
        mcnt[k]  = 8'h0;
      end
      n_acc = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (exp_q[k].size() != 0 && o_ready[k]) begin
          void'(exp_q[k].pop_front());
          if (mcnt[k] != 8'hFF) mcnt[k] = mcnt[k] + 8'd1;
        end
      end
      if (acc) begin
        exp_q[s].push_back(i);
        mlast[s] = i;
        n_acc++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt[k*8 +: 8] !== mcnt[k]) begin
        failures++;
        $display("FAIL cnt lane%0d got %0d exp %0d at %0t", k, cnt[k*8 +: 8], mcnt[k], $time);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i = 4'h0; s = 2'd0; i_valid = 1'b0; o_ready = 4'h0;
    i2 = 4'h0; s2 = 2'd0; v2 = 1'b0; r2 = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (o_valid !== 4'b0000 || cnt !== 32'h0 || {o1, o2, o3, o4} !== 16'h0 || i_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state o_valid=%b cnt=%h o=%h i_ready=%b exp 0000/0/0/1",
               o_valid, cnt, {o1, o2, o3, o4}, i_ready);
    end
  endtask

  task automatic test_single();
    i = 4'hA; s = 2'd2; i_valid = 1'b1; o_ready = 4'b1111;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o3 !== 4'hA || o_valid !== 4'b0100) begin
      failures++;
      $display("FAIL single_load o3=%h o_valid=%b exp a/0100", o3, o_valid);
    end
    tick();
    checks++;
    if (o_valid !== 4'b0000 || cnt[2*8 +: 8] !== 8'd1) begin
      failures++;
      $display("FAIL single_drain o_valid=%b cnt2=%0d exp 0000/1", o_valid, cnt[2*8 +: 8]);
    end
  endtask

  task automatic test_backpressure();
    o_ready = 4'b0000;
    i = 4'h3; s = 2'd0; i_valid = 1'b1;
    tick();
    i = 4'h5;
    tick();
    tick();
    checks++;
    if (i_ready !== 1'b0 || o1 !== 4'h3) begin
      failures++;
      $display("FAIL backpressure_hold i_ready=%b o1=%h exp 0/3", i_ready, o1);
    end
    o_ready = 4'b0001;
    tick();
    i_valid = 1'b0; o_ready = 4'b0000;
    checks++;
    if (o_valid[0] !== 1'b1 || o1 !== 4'h5 || cnt[7:0] !== 8'd1) begin
      failures++;
      $display("FAIL backpressure_refill v0=%b o1=%h cnt0=%0d exp 1/5/1", o_valid[0], o1, cnt[7:0]);
    end
  endtask

  task automatic test_lane_indep();
    o_ready = 4'b0000;
    i_valid = 1'b1;
    for (int k = 1; k < 4; k++) begin
      i = 4'(k); s = 2'(k);
      tick();
    end
    i_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 4'b1111 || o1 !== 4'h5 || {o2, o3, o4} !== 12'h123) begin
      failures++;
      $display("FAIL lane_indep o_valid=%b o1=%h o2..o4=%h exp 1111/5/123", o_valid, o1, {o2, o3, o4});
    end
  endtask

  task automatic test_reset_midop();
    o_ready = 4'b1010;
    tick();
    o_ready = 4'b0000;
    rst = 1'b1; i = 4'h7; s = 2'd1; i_valid = 1'b1;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    tick();
    checks++;
    if (o_valid !== 4'b0000 || cnt !== 32'h0 || o2 !== 4'h0) begin
      failures++;
      $display("FAIL reset_midop o_valid=%b cnt=%h o2=%h exp 0000/0/0", o_valid, cnt, o2);
    end
  endtask

  // mux4_1 vector table: {i1,i2,i3,i4} and s; the delivered word is the one s selects.
  typedef struct packed { logic [15:0] ins; logic [1:0] sel; } vec_t;
  localparam vec_t VECS [10] = '{
    '{16'h1234, 2'd0}, '{16'h1234, 2'd1}, '{16'h1234, 2'd2}, '{16'h1234, 2'd3},
    '{16'hF0A5, 2'd2}, '{16'h9C3E, 2'd0}, '{16'h5AA5, 2'd3}, '{16'hE7B1, 2'd1},
    '{16'h0F0F, 2'd2}, '{16'h8421, 2'd2}
  };

  task automatic test_vectors();
    int budget;
    vec_t v;
    for (int n = 0; n < 10; n++) begin
      v = VECS[n];
      i = v.ins[(3 - v.sel)*4 +: 4];
      s = v.sel;
      i_valid = 1'b1;
      budget = 0;
      last_acc = 1'b0;
      while (!last_acc && budget < 40) begin
        o_ready = 4'($urandom_range(0, 15));
        tick();
        budget++;
      end
      checks++;
      if (!last_acc) begin
        failures++;
        $display("FAIL vector%0d not accepted within %0d cycles", n, budget);
      end
    end
    i_valid = 1'b0;
    o_ready = 4'b1111;
    tick();
    tick();
    checks++;
    if ((32'(cnt[7:0]) + 32'(cnt[15:8]) + 32'(cnt[23:16]) + 32'(cnt[31:24])) !== 32'(n_acc) || n_acc != 10) begin
      failures++;
      $display("FAIL cnt_sum got %0d exp %0d (accepted %0d of 10)",
               32'(cnt[7:0]) + 32'(cnt[15:8]) + 32'(cnt[23:16]) + 32'(cnt[31:24]), n_acc, n_acc);
    end
    o_ready = 4'b0000;
  endtask

  task automatic test_saturation();
    r2 = 4'b1000; s2 = 2'd3; v2 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      i2 = 4'(n + 1);
      @(negedge clk);
      checks++;
      if (rdy2 !== 1'b1) begin
        failures++;
        $display("FAIL sat_ready word%0d got %b exp 1", n, rdy2);
      end
      @(posedge clk); #1;
      if (n == 2) begin
        checks++;
        if (cnt2[7:6] !== 2'd2) begin
          failures++;
          $display("FAIL sat_mid got %0d exp 2", cnt2[7:6]);
        end
      end
    end
    v2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cnt2[7:6] !== 2'd3 || cnt2[5:0] !== 6'd0 || pv !== 4'b0000) begin
      failures++;
      $display("FAIL sat_final cnt3=%0d others=%h pv=%b exp 3/0/0000", cnt2[7:6], cnt2[5:0], pv);
    end
    v2 = 1'b1; i2 = 4'hC;
    @(posedge clk); #1;
    v2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cnt2[7:6] !== 2'd3) begin
      failures++;
      $display("FAIL sat_hold got %0d exp 3", cnt2[7:6]);
    end
    r2 = 4'b0000;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      mlast[k] = 4'h0;
      mcnt[k]  = 8'h0;
    end
    n_acc = 0;
    last_acc = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_lane_indep();
    test_reset_midop();
    test_vectors();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
